// File: rtl/fdiv_iter_if.sv
// Handshake and operand bus for the iterative FP divider.
// The master drives the request and operands; the slave returns busy/done/out.
interface fdiv_iter_if;
  logic        start;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] out;

  modport master (
    output start,
    output rs1,
    output rs2,
    input  busy,
    input  done,
    input  out
  );

  modport slave (
    input  start,
    input  rs1,
    input  rs2,
    output busy,
    output done,
    output out
  );
endinterface

// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative IEEE-754 single-precision divider, out = rs1 / rs2.
// Restoring radix-2 datapath, one quotient bit per cycle. Subnormal inputs
// are flushed to zero.
// Optional macro FDIV_ROUND_EN: computes one extra guard bit plus sticky and
// rounds to nearest-even. Without it the result is truncated.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched and decoded on the start edge
//   DIV   | one restoring-division step per cycle, counter runs down to 0
//   NORM  | normalise quotient, apply overflow/underflow, register out
//   DONE  | done pulse for one cycle, then back to IDLE
module fdiv_iter #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fdiv_iter_if.slave    bus
);

`ifdef FDIV_ROUND_EN
  localparam int QBITS = 26;
`else
  localparam int QBITS = 25;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        m2_q, m2_d;
  logic [24:0]        rem_q, rem_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        out_q, out_d;

  // Operand decode signals
  logic [7:0]         e1, e2;
  logic [22:0]        f1, f2;
  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;
  logic               sign_in;
  logic signed [9:0]  exp_in;
  logic               special;
  logic [31:0]        special_res;

  // Division step signals
  logic [25:0]        diff;
  logic               qbit;
  logic [24:0]        rem_sub;
  logic [24:0]        rem_nxt;

  // Normalisation signals
  logic signed [9:0]  exp_n;
  logic [22:0]        mant_n;
  logic [31:0]        norm_res;

  // Field extraction and classification of the incoming operands
  always_comb begin
    e1      = bus.rs1[30:23];
    e2      = bus.rs2[30:23];
    f1      = bus.rs1[22:0];
    f2      = bus.rs2[22:0];
    a_zero  = (e1 == 8'h00);
    b_zero  = (e2 == 8'h00);
    a_inf   = (e1 == 8'hFF) && (f1 == 23'h0);
    b_inf   = (e2 == 8'hFF) && (f2 == 23'h0);
    a_nan   = (e1 == 8'hFF) && (f1 != 23'h0);
    b_nan   = (e2 == 8'hFF) && (f2 != 23'h0);
    sign_in = bus.rs1[31] ^ bus.rs2[31];
    exp_in  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;

    special     = 1'b1;
    special_res = 32'h0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res = CANON_NAN;
    end else if (b_zero || a_inf) begin
      special_res = {sign_in, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      special_res = {sign_in, 31'h0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step: trial-subtract, keep or restore, shift left
  always_comb begin
    diff    = {1'b0, rem_q} - {2'b00, m2_q};
    qbit    = ~diff[25];
    rem_sub = qbit ? diff[24:0] : rem_q;
    rem_nxt = {rem_sub[23:0], 1'b0};
  end

`ifdef FDIV_ROUND_EN
  logic               lead;
  logic [22:0]        mant_t;
  logic               guard;
  logic               sticky;
  logic               rnd;
  logic [23:0]        mant_sum;
  logic signed [9:0]  exp_t;

  // Normalise the 26-bit quotient and round to nearest-even
  always_comb begin
    lead     = quo_q[25];
    mant_t   = lead ? quo_q[24:2] : quo_q[23:1];
    guard    = lead ? quo_q[1] : quo_q[0];
    sticky   = (lead & quo_q[0]) | (rem_q != 25'h0);
    exp_t    = lead ? exp_q : (exp_q - 10'sd1);
    rnd      = guard & (sticky | mant_t[0]);
    mant_sum = {1'b0, mant_t} + {23'h0, rnd};
    mant_n   = mant_sum[22:0];
    exp_n    = mant_sum[23] ? (exp_t + 10'sd1) : exp_t;
  end
`else
  // Normalise the 25-bit quotient by truncation
  always_comb begin
    mant_n = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    exp_n  = quo_q[24] ? exp_q : (exp_q - 10'sd1);
  end
`endif

  // Range check of the normalised exponent
  always_comb begin
    if (exp_n >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'h0};
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sign_q, 31'h0};
    end else begin
      norm_res = {sign_q, exp_n[7:0], mant_n};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    m2_d    = m2_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d = sign_in;
          exp_d  = exp_in;
          m2_d   = {1'b1, f2};
          rem_d  = {2'b01, f1};
          quo_d  = '0;
          cnt_d  = 5'(QBITS - 1);
          if (special) begin
            out_d   = special_res;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_nxt;
        quo_d = {quo_q[QBITS-2:0], qbit};
        if (cnt_q == 5'd0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      NORM: begin
        out_d   = norm_res;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      m2_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      m2_q    <= m2_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy = (state_q == DIV) || (state_q == NORM);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed testbench for fdiv_iter: table of operand/result/latency vectors
// plus hand-written sequences for start-while-busy and mid-division reset.
module tb_fdiv_iter;

`ifdef FDIV_ROUND_EN
  localparam int NL = 28;
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
  localparam logic [31:0] TWO_THIRD = 32'h3F2AAAAB;
`else
  localparam int NL = 27;
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
  localparam logic [31:0] TWO_THIRD = 32'h3F2AAAAA;
`endif
  localparam int NV = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t vecs [NV];

  fdiv_iter_if bus ();

  fdiv_iter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Issue one operation and count rising edges, starting with the start
  // edge, until done is observed high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit busy_bad,
                       output bit busy_at_done);
    @(negedge clk);
    bus.rs1   = a;
    bus.rs2   = b;
    bus.start = 1'b1;
    @(posedge clk);
    lat      = 1;
    busy_bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res          = bus.out;
    busy_at_done = bus.busy;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          busy_bad;
    bit          busy_at_done;
    bit          seen_done;

    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, NL};
    vecs[1]  = '{32'h3F800000, 32'h40400000, ONE_THIRD,    NL};
    vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, NL};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, NL};
    vecs[7]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1};
    vecs[8]  = '{32'hC0F00000, 32'h40200000, 32'hC0400000, NL};
    vecs[9]  = '{32'h40400000, 32'h40800000, 32'h3F400000, NL};
    vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1};
    vecs[11] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1};
    vecs[12] = '{32'h40000000, 32'hFF800000, 32'h80000000, 1};
    vecs[13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, NL};
    vecs[14] = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1};
    vecs[15] = '{32'h3F800000, 32'h3FC00000, TWO_THIRD,    NL};

    bus.start = 1'b0;
    bus.rs1   = 32'h0;
    bus.rs2   = 32'h0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_done", {31'h0, bus.done}, 32'h0);
    check("reset_out",  bus.out,           32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, lat, busy_bad, busy_at_done);
      check($sformatf("vec%0d_out", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_gap", i), {31'h0, busy_bad}, 32'h0);
      check($sformatf("vec%0d_busy_at_done", i), {31'h0, busy_at_done}, 32'h0);
    end

    // Second start 5 cycles into a division must be ignored
    @(negedge clk);
    bus.rs1   = 32'h40C00000;
    bus.rs2   = 32'h40000000;
    bus.start = 1'b1;
    @(posedge clk);
    lat      = 1;
    busy_bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      if (lat == 5) begin
        bus.rs1   = 32'h3F800000;
        bus.rs2   = 32'h40400000;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (!bus.busy) busy_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_start_out", bus.out, 32'h40400000);
    check("busy_start_latency", 32'(lat), 32'(NL));
    check("busy_start_busy_gap", {31'h0, busy_bad}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_start_idle_after", {31'h0, bus.busy}, 32'h0);

    // Reset 10 cycles into DIV aborts without a done pulse
    @(negedge clk);
    bus.rs1   = 32'h3F800000;
    bus.rs2   = 32'h40400000;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    check("abort_done", {31'h0, bus.done}, 32'h0);
    check("abort_out",  bus.out,           32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("abort_no_done", {31'h0, seen_done}, 32'h0);

    do_op(32'h40C00000, 32'h40000000, res, lat, busy_bad, busy_at_done);
    check("post_reset_out", res, 32'h40400000);
    check("post_reset_latency", 32'(lat), 32'(NL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fdiv_iter.md
Name: fdiv_iter

Overview:
- Iterative IEEE-754 single-precision divider (out = rs1 / rs2).
- Inverse of the pipelined FP multiplier; sits beside it in the FPU execute stage.
- Restoring radix-2 divider, one quotient bit per cycle, with a start/busy/done handshake.
- Subnormal inputs flush to zero; default rounding is truncation.

Parameters:
- CANON_NAN, 32'h7FC00000, value driven on out for every NaN result.
- QBITS, 25, quotient bits computed per operation without rounding. Must be 25; 26 is forced when FDIV_ROUND_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- rs1  input  32  dividend, sampled on the start edge.
- rs2  input  32  divisor, sampled on the start edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; out is valid from this cycle.
- out  output  32  quotient; holds its value until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, out=0; all internal registers cleared.
  - Applies immediately, including mid-division; the operation is aborted and no done is issued.
- States: IDLE -> DIV -> NORM -> DONE -> IDLE, plus a special-case path IDLE -> DONE.
- Accepted start (IDLE and start=1): latch operands, set busy=1.
- start while busy=1 is ignored.
- Operand decode:
  - s = rs1[31]^rs2[31].
  - An input is zero when exp==0 (subnormals flushed).
  - An input is inf when exp==255 and frac==0; NaN when exp==255 and frac!=0.
  - M1, M2 = {1, frac} (24 bits).
  - e = e1 - e2 + 127, held as a 10-bit signed value.
- Special cases, resolved at latch time; next state DONE (done 1 cycle after the start edge):
  - NaN input, 0/0 or inf/inf -> CANON_NAN.
  - x/0 or inf/x -> {s, 8'hFF, 23'h0}.
  - 0/x or x/inf -> {s, 31'h0}.
- DIV:
  - Restoring division over exactly QBITS cycles; cycle counter counts down to 0.
  - Result q = floor((M1 << 24) / M2), 25 bits.
  - Per cycle: trial-subtract the divisor from the partial remainder; shift in the quotient bit; remainder shifts left 1.
- NORM (1 cycle):
  - If q[24]=1: mant=q[23:1], exp=e.
  - Else: mant=q[22:0], exp=e-1.
  - exp >= 255 -> {s, 8'hFF, 0}.
  - exp <= 0 -> {s, 31'h0}.
  - Otherwise -> {s, exp[7:0], mant}.
- DONE (1 cycle):
  - done=1, busy=0; out registered.
  - Next state IDLE; a new start is accepted from the following cycle.
- Normal latency: done asserted 27 cycles after the start edge (1 latch + 25 DIV + NORM).
- busy is high during the cycles between the start edge and the done edge.

Optional Feature:
- Macro: FDIV_ROUND_EN.
- Defined:
  - DIV runs 26 cycles, producing one guard bit; sticky = (final remainder != 0).
  - Round to nearest-even on the normalised mantissa.
  - A mantissa carry-out increments exp, and the overflow check is re-applied.
  - Normal latency is 28 cycles.
- Undefined: truncation, 25 DIV cycles, no sticky logic.

Test Plan:
- rs1=0x40C00000, rs2=0x40000000 (6/2), start pulse -> out=0x40400000; done 27 cycles after the start edge, busy high in between.
- rs1=0x3F800000, rs2=0x40400000 (1/3) -> out=0x3EAAAAAA without the macro; with FDIV_ROUND_EN, out=0x3EAAAAAB at 28 cycles.
- Special cases:
  - 0xBF800000 / 0x00000000 -> 0xFF800000, done 1 cycle after start.
  - 0/0 -> 0x7FC00000.
  - 0x7F800001 / 0x3F800000 -> 0x7FC00000.
- Range limits:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow).
  - 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush).
  - 0x00000001 / 0x3F800000 -> 0x00000000 (subnormal flush).
- Handshake and reset:
  - Second start asserted 5 cycles into a division is ignored; out reflects the first operands.
  - reset asserted 10 cycles into DIV -> busy=0, done=0, out=0 asynchronously, no done pulse.
  - After release, 6/2 completes correctly.
